// File: rtl/alu_seq.sv
// Sequential 16-bit ALU (add/sub/AND/OR) processing SLICE_W bits per cycle.
// Optional zero flag output is enabled by defining ALU_SEQ_ZERO_FLAG_EN.
module alu_seq #(
  parameter int SLICE_W = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_op,
  input  logic [15:0] in_i0,
  input  logic [15:0] in_i1,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] o,
  output logic        cout
`ifdef ALU_SEQ_ZERO_FLAG_EN
  ,
  output logic        zero
`endif
);

  localparam int N  = 16 / SLICE_W;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state;
  logic [1:0]         op_q;
  logic [15:0]        a_q;
  logic [15:0]        b_q;
  logic [15:0]        res_q;
  logic               carry;
  logic [CW-1:0]      cnt;

  logic [3:0]         base;
  logic [SLICE_W-1:0] a_sl;
  logic [SLICE_W-1:0] b_sl;
  logic [SLICE_W-1:0] s_sl;
  logic [SLICE_W:0]   sum;
  logic               c_nxt;
  logic [15:0]        res_nxt;
  logic               last;

  // Subtract reuses the adder: b is inverted per slice and the carry was seeded with 1.
  always_comb begin
    base    = 4'(32'(cnt) * SLICE_W);
    a_sl    = a_q[base +: SLICE_W];
    b_sl    = b_q[base +: SLICE_W];
    sum     = {1'b0, a_sl} + {1'b0, (op_q[0] ? ~b_sl : b_sl)} + {{SLICE_W{1'b0}}, carry};
    case (op_q)
      2'b10:   s_sl = a_sl & b_sl;
      2'b11:   s_sl = a_sl | b_sl;
      default: s_sl = sum[SLICE_W-1:0];
    endcase
    c_nxt   = ~op_q[1] & sum[SLICE_W];
    res_nxt = res_q;
    res_nxt[base +: SLICE_W] = s_sl;
    last    = (cnt == CW'(N - 1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      o         <= '0;
      cout      <= 1'b0;
`ifdef ALU_SEQ_ZERO_FLAG_EN
      zero      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_q     <= in_op;
            a_q      <= in_i0;
            b_q      <= in_i1;
            carry    <= (in_op == 2'b01);
            cnt      <= '0;
            res_q    <= '0;
            in_ready <= 1'b0;
            state    <= CALC;
          end
        end
        CALC: begin
          res_q <= res_nxt;
          carry <= c_nxt;
          cnt   <= cnt + 1'b1;
          if (last) begin
            o         <= res_nxt;
            cout      <= c_nxt;
`ifdef ALU_SEQ_ZERO_FLAG_EN
            zero      <= (res_nxt == 16'h0000);
`endif
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed and random commands against an arithmetic reference model,
// plus backpressure, mid-calculation reset, and SLICE_W=1/16 latency checks.
module tb_alu_seq;
  localparam int SW = 4;
  localparam int N  = 16 / SW;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        vld_w = 1'b0;
  logic [1:0]  in_op = '0;
  logic [15:0] in_i0 = '0;
  logic [15:0] in_i1 = '0;
  logic        out_ready = 1'b1;
  logic        in_ready, out_valid, cout;
  logic [15:0] o;
  logic        rdy1, ov1, c1, rdy16, ov16, c16;
  logic [15:0] o1, o16;
`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic        zero, z1, z16;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_seq #(.SLICE_W(SW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_i0(in_i0), .in_i1(in_i1), .out_valid(out_valid), .out_ready(out_ready), .o(o), .cout(cout)
`ifdef ALU_SEQ_ZERO_FLAG_EN
    , .zero(zero)
`endif
  );

  alu_seq #(.SLICE_W(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(vld_w), .in_ready(rdy1), .in_op(in_op),
    .in_i0(in_i0), .in_i1(in_i1), .out_valid(ov1), .out_ready(1'b1), .o(o1), .cout(c1)
`ifdef ALU_SEQ_ZERO_FLAG_EN
    , .zero(z1)
`endif
  );

  alu_seq #(.SLICE_W(16)) dut16 (
    .clk(clk), .reset(reset), .in_valid(vld_w), .in_ready(rdy16), .in_op(in_op),
    .in_i0(in_i0), .in_i1(in_i1), .out_valid(ov16), .out_ready(1'b1), .o(o16), .cout(c16)
`ifdef ALU_SEQ_ZERO_FLAG_EN
    , .zero(z16)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: whole-word arithmetic, 17-bit result carries cout in bit 16.
  function automatic logic [16:0] model(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      2'b00:   return {1'b0, a} + {1'b0, b};
      2'b01:   return {1'b0, a} + {1'b0, ~b} + 17'd1;
      2'b10:   return {1'b0, a & b};
      default: return {1'b0, a | b};
    endcase
  endfunction

  // Called just after a rising edge; issues one command and checks result and latency.
  task automatic do_cmd(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b, input string tag);
    logic [16:0] exp;
    int lat;
    exp = model(op, a, b);
    in_op = op; in_i0 = a; in_i1 = b; in_valid = 1'b1;
    chk({tag, "_rdy_pre"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_i0 = $urandom; in_i1 = $urandom; in_op = 2'($urandom);
    chk({tag, "_rdy_busy"}, 32'(in_ready), 32'd0);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(N));
    chk({tag, "_o"}, 32'(o), 32'(exp[15:0]));
    chk({tag, "_cout"}, 32'(cout), 32'(exp[16]));
`ifdef ALU_SEQ_ZERO_FLAG_EN
    chk({tag, "_zero"}, 32'(zero), 32'(exp[15:0] == 16'h0));
`endif
    if (out_ready) begin
      @(posedge clk); #1;
      chk({tag, "_ov_drop"}, 32'(out_valid), 32'd0);
      chk({tag, "_rdy_back"}, 32'(in_ready), 32'd1);
    end
  endtask

  initial begin
    logic [16:0] exp;
    logic [1:0]  vop [2];
    logic [15:0] va  [2];
    logic [15:0] vb  [2];
    int l1, l16;

    #1;
    chk("rst_ov", 32'(out_valid), 32'd0);
    chk("rst_o", 32'(o), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
`ifdef ALU_SEQ_ZERO_FLAG_EN
    chk("rst_zero", 32'(zero), 32'd0);
`endif
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_rdy", 32'(in_ready), 32'd1);
    // first command on the very first edge after release
    do_cmd(2'b00, 16'haa55, 16'h55aa, "add_aa55");
    do_cmd(2'b00, 16'hffff, 16'h0001, "add_wrap");
    do_cmd(2'b01, 16'h0001, 16'h7fff, "sub_neg");
    do_cmd(2'b01, 16'h0000, 16'h0000, "sub_zero");
    do_cmd(2'b10, 16'haa55, 16'h55aa, "and");
    do_cmd(2'b11, 16'hffff, 16'h0001, "or");
    for (int i = 0; i < 40; i++) do_cmd(2'($urandom), 16'($urandom), 16'($urandom), "rnd");

    // Backpressure: result held, competing command ignored.
    out_ready = 1'b0;
    exp = model(2'b01, 16'h1234, 16'h0235);
    do_cmd(2'b01, 16'h1234, 16'h0235, "bp");
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_op = 2'b11; in_i0 = 16'hffff; in_i1 = 16'hffff;
      @(posedge clk); #1;
      chk("bp_ov", 32'(out_valid), 32'd1);
      chk("bp_o", 32'(o), 32'(exp[15:0]));
      chk("bp_cout", 32'(cout), 32'(exp[16]));
      chk("bp_rdy", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_ov", 32'(out_valid), 32'd0);
    chk("bp_release_rdy", 32'(in_ready), 32'd1);
    do_cmd(2'b00, 16'h0f0f, 16'h00f1, "after_bp");

    // Reset during CALC cycle 2; o must clear with no clock edge.
    do_cmd(2'b11, 16'hff00, 16'h00ff, "pre_rst");
    in_valid = 1'b1; in_op = 2'b00; in_i0 = 16'h1111; in_i1 = 16'h2222;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    chk("arst_ov", 32'(out_valid), 32'd0);
    chk("arst_o", 32'(o), 32'd0);
    chk("arst_cout", 32'(cout), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    do_cmd(2'b00, 16'h0001, 16'h7fff, "post_rst");
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("no_ghost_ov", 32'(out_valid), 32'd0);
    end

    // Slice widths 1 and 16 on the same vectors.
    vop[0] = 2'b00; va[0] = 16'haa55; vb[0] = 16'h55aa;
    vop[1] = 2'b00; va[1] = 16'hffff; vb[1] = 16'h0001;
    for (int v = 0; v < 2; v++) begin
      exp = model(vop[v], va[v], vb[v]);
      in_op = vop[v]; in_i0 = va[v]; in_i1 = vb[v]; vld_w = 1'b1;
      @(posedge clk); #1;
      vld_w = 1'b0;
      l1 = -1; l16 = -1;
      for (int c = 1; c <= 24; c++) begin
        if (ov1 && l1 < 0) begin
          l1 = c - 1;
          chk("w1_o", 32'(o1), 32'(exp[15:0]));
          chk("w1_cout", 32'(c1), 32'(exp[16]));
`ifdef ALU_SEQ_ZERO_FLAG_EN
          chk("w1_zero", 32'(z1), 32'(exp[15:0] == 16'h0));
`endif
        end
        if (ov16 && l16 < 0) begin
          l16 = c - 1;
          chk("w16_o", 32'(o16), 32'(exp[15:0]));
          chk("w16_cout", 32'(c16), 32'(exp[16]));
`ifdef ALU_SEQ_ZERO_FLAG_EN
          chk("w16_zero", 32'(z16), 32'(exp[15:0] == 16'h0));
`endif
        end
        @(posedge clk); #1;
      end
      chk("w1_lat", 32'(l1), 32'd16);
      chk("w16_lat", 32'(l16), 32'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish before 200000");
    $fatal(1);
  end
endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter SLICE_W, default 4, bits processed per CALC cycle; legal values 1, 2, 4, 8, 16.
REQ-002 SHALL have clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have in_valid  input  1  command present.
REQ-005 SHALL have in_ready  output  1  block can accept a command.
REQ-006 SHALL have in_op  input  2  operation: 00 add, 01 subtract (i0-i1), 10 AND, 11 OR.
REQ-007 SHALL have in_i0  input  16  first operand.
REQ-008 SHALL have in_i1  input  16  second operand.
REQ-009 SHALL have out_valid  output  1  result present.
REQ-010 SHALL have out_ready  input  1  consumer takes result.
REQ-011 SHALL have o  output  16  result.
REQ-012 SHALL have cout  output  1  carry out.
REQ-013 SHALL have zero  output  1  result-is-zero flag, present only with ALU_SEQ_ZERO_FLAG_EN.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, DONE.
REQ-015 SHALL assert in_ready only in IDLE; command accepted on rising edge with in_valid=1 and in_ready=1.
REQ-016 SHALL on acceptance capture in_op, in_i0 and in_i1 into internal registers and enter CALC; later input changes are ignored.
REQ-017 SHALL in CALC process one SLICE_W-bit slice per cycle, LSB slice first, for N=16/SLICE_W cycles, with a 1-bit carry register between slices.
REQ-018 SHALL initialise the carry register to 0 for add and to 1 for subtract, with subtract computed as i0 + ~i1 + 1.
REQ-019 SHALL set cout to the carry out of bit 15 for add/subtract (subtract: 1 = no borrow) and to 0 for AND/OR.
REQ-020 SHALL enter DONE after the Nth CALC cycle; out_valid rises N cycles after the accepting edge.
REQ-021 SHALL hold o, cout (and zero) stable while out_valid=1 and out_ready=0.
REQ-022 SHALL on out_valid=1 and out_ready=1 at a rising edge deassert out_valid and return to IDLE; in_ready rises on that same edge.
REQ-023 SHALL not accept a new command in CALC or DONE; minimum command spacing is N+2 cycles.
REQ-024 SHALL have o retain the last completed result outside DONE; o is defined only while out_valid=1.
REQ-025 SHALL wrap arithmetic modulo 2^16 (ffff+0001 gives 0000, cout=1).

Reset
REQ-026 SHALL on reset assertion, asynchronously and independent of clk: state IDLE; in_ready=1 after release; out_valid=0; o=0; cout=0; zero=0; internal registers cleared.
REQ-027 SHALL discard any command in CALC or DONE when reset asserts, with no out_valid pulse afterwards.
REQ-028 SHALL accept the first command on the first rising edge after reset deasserts.

Configuration
REQ-029 SHALL, with macro ALU_SEQ_ZERO_FLAG_EN defined, provide output zero = 1 when o==16'h0000, valid with out_valid and reset to 0.
REQ-030 SHALL, without ALU_SEQ_ZERO_FLAG_EN, omit port zero and its logic; all other behaviour is identical.

Verification
REQ-031 SHALL cover add aa55+55aa -> o=ffff, cout=0, out_valid exactly 4 cycles after acceptance (SLICE_W=4); add ffff+0001 -> o=0000, cout=1, zero=1 (macro on).
REQ-032 SHALL cover subtract: 0001-7fff -> o=8002, cout=0; 0000-0000 -> o=0000, cout=1.
REQ-033 SHALL cover logic ops: AND aa55,55aa -> o=0000, cout=0; OR ffff,0001 -> o=ffff, cout=0.
REQ-034 SHALL cover backpressure: out_ready held 0 for 5 cycles -> o/cout stable, in_ready=0 and a second in_valid ignored; out_ready=1 -> in_ready=1 on the next edge.
REQ-035 SHALL cover reset asserted on CALC cycle 2 -> out_valid=0, o=0 immediately with no clock edge; next command 0001+7fff -> o=8000, cout=0.
REQ-036 SHALL cover SLICE_W=1 and SLICE_W=16 with the REQ-031 vectors -> identical results with latency 16 and 1 cycles respectively.
